seq_mult_param: RTL

//  - Parametrised shift-add sequential multiplier with integrated control FSM and start/done handshake.
//  - Generalises the fixed 4-bit multiplier datapath to WIDTH-bit operands; one iteration (add + shift) per cycle.
//  - Sits between an operand producer (pulses start_i) and a result consumer (samples product_o on done_o).

---
 rtl/seq_mult_param.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_mult_param.sv
// seq_mult_param: WIDTH-bit shift-add sequential multiplier with start/done handshake.
// One add+shift iteration per clock. A result appears WIDTH+1 cycles after an accepted start.
// Optional build macro: SIGNED_MULT_EN selects two's-complement operands.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i; product_o holds the last result
// RUN   | one add+shift per cycle; cnt counts down to the final iteration
// DONE  | single-cycle done_o pulse; start_i here restarts directly into RUN
module seq_mult_param #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   multplcnd_i,
  input  logic [WIDTH-1:0]   multplr_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             load;
  logic             step;
  logic             last;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] b_nx;

  assign last = (cnt_q == '0);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        busy_o = 1'b1;
        step   = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done_o = 1'b1;
        if (start_i) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SIGNED_MULT_EN
  assign a_ext = {a_q[WIDTH-1], a_q};

  // Signed partial sum: the multiplier MSB carries negative weight, so the last iteration subtracts
  always_comb begin
    sum = acc_q;
    if (b_q[0]) begin
      if (last) sum = acc_q - a_ext;
      else      sum = acc_q + a_ext;
    end
  end

  assign acc_nx = {sum[WIDTH], sum[WIDTH:1]};
`else
  assign a_ext = {1'b0, a_q};

  // Unsigned partial sum; the carry lands in acc[WIDTH] and is shifted down next
  always_comb begin
    sum = acc_q;
    if (b_q[0]) sum = acc_q + a_ext;
  end

  assign acc_nx = {1'b0, sum[WIDTH:1]};
`endif

  // The low bit of the sum shifts into the top of B, retiring one multiplier bit per cycle
  assign b_nx = {sum[0], b_q[WIDTH-1:1]};

  // Operand capture and iteration datapath
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      a_q   <= multplcnd_i;
      b_q   <= multplr_i;
      acc_q <= '0;
      cnt_q <= CNT_W'(WIDTH - 1);
    end else if (step) begin
      acc_q <= acc_nx;
      b_q   <= b_nx;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Result register: loaded only on the edge entering DONE so it stays put through later operations
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)          product_o <= '0;
    else if (step && last) product_o <= {acc_nx[WIDTH-1:0], b_nx};
  end

endmodule
